// File: rtl/alu_issue.sv
// alu_issue: RV32I decode-and-issue stage in front of the ALU.
// Decodes operands/opcode combinationally and queues them in a 2-entry FIFO.
module alu_issue #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        flush,
    input  logic        inValid,
    output logic        inReady,
    input  logic [31:0] inInstr,
    input  logic [31:0] inPc,
    input  logic [31:0] inRs1Val,
    input  logic [31:0] inRs2Val,
    output logic        outValid,
    input  logic        outReady,
    output logic [31:0] dataIn0,
    output logic [31:0] dataIn1,
    output logic [3:0]  operation,
    output logic [4:0]  rdIndex,
    output logic        writesRd,
    output logic        isBranch,
    output logic        illegal
);

    localparam logic [3:0] ALU_EQ  = 4'd0;
    localparam logic [3:0] ALU_NE  = 4'd1;
    localparam logic [3:0] ALU_LT  = 4'd2;
    localparam logic [3:0] ALU_GE  = 4'd3;
    localparam logic [3:0] ALU_LTU = 4'd4;
    localparam logic [3:0] ALU_GEU = 4'd5;
    localparam logic [3:0] ALU_ADD = 4'd6;
    localparam logic [3:0] ALU_XOR = 4'd7;
    localparam logic [3:0] ALU_OR  = 4'd8;
    localparam logic [3:0] ALU_AND = 4'd9;
    localparam logic [3:0] ALU_SUB = 4'd10;
    localparam logic [3:0] ALU_SLL = 4'd11;
    localparam logic [3:0] ALU_SRL = 4'd12;
    localparam logic [3:0] ALU_SRA = 4'd13;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic [31:0] d0;
        logic [31:0] d1;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        wrd;
        logic        br;
        logic        ill;
    } entry_t;

    // Shared OP / OP-IMM funct decode; returns {legal, op}.
    function automatic logic [4:0] alu_map(
        input logic [2:0] f3,
        input logic [6:0] f7,
        input logic       imm
    );
        logic       zero;
        logic       alt;
        logic [4:0] res;
        zero = (f7 == 7'b0000000);
        alt  = (f7 == 7'b0100000);
        res  = {1'b0, ALU_ADD};
        unique case (f3)
            3'b000: begin
                if (imm) res = {1'b1, ALU_ADD};
                else     res = {zero | alt, alt ? ALU_SUB : ALU_ADD};
            end
            3'b001: res = {zero, ALU_SLL};
            3'b010: res = {imm | zero, ALU_LT};
            3'b011: res = {imm | zero, ALU_LTU};
            3'b100: res = {imm | zero, ALU_XOR};
            3'b101: res = {zero | alt, alt ? ALU_SRA : ALU_SRL};
            3'b110: res = {imm | zero, ALU_OR};
            3'b111: res = {imm | zero, ALU_AND};
        endcase
        return res;
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;

    assign opcode = inInstr[6:0];
    assign rd     = inInstr[11:7];
    assign funct3 = inInstr[14:12];
    assign funct7 = inInstr[31:25];
    assign imm_i  = {{20{inInstr[31]}}, inInstr[31:20]};
    assign imm_s  = {{20{inInstr[31]}}, inInstr[31:25], inInstr[11:7]};
    assign imm_u  = {inInstr[31:12], 12'b0};

    entry_t     dec;
    logic       legal;
    logic       wr;
    logic [4:0] map;

    always_comb begin
        dec    = '0;
        dec.op = ALU_ADD;
        dec.rd = rd;
        legal  = 1'b1;
        wr     = 1'b1;
        map    = '0;
        unique case (opcode)
            OPC_OP: begin
                map    = alu_map(funct3, funct7, 1'b0);
                legal  = map[4];
                dec.op = map[3:0];
                dec.d0 = inRs1Val;
                dec.d1 = inRs2Val;
            end
            OPC_OPIMM: begin
                map    = alu_map(funct3, funct7, 1'b1);
                legal  = map[4];
                dec.op = map[3:0];
                dec.d0 = inRs1Val;
                dec.d1 = imm_i;
            end
            OPC_BRANCH: begin
                wr     = 1'b0;
                dec.br = 1'b1;
                dec.d0 = inRs1Val;
                dec.d1 = inRs2Val;
                unique case (funct3)
                    3'b000:  dec.op = ALU_EQ;
                    3'b001:  dec.op = ALU_NE;
                    3'b100:  dec.op = ALU_LT;
                    3'b101:  dec.op = ALU_GE;
                    3'b110:  dec.op = ALU_LTU;
                    3'b111:  dec.op = ALU_GEU;
                    default: legal  = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                dec.d0 = inRs1Val;
                dec.d1 = imm_i;
            end
            OPC_STORE: begin
                wr     = 1'b0;
                dec.d0 = inRs1Val;
                dec.d1 = imm_s;
            end
            OPC_LUI: begin
                dec.d1 = imm_u;
            end
            OPC_AUIPC: begin
                dec.d0 = inPc;
                dec.d1 = imm_u;
            end
            OPC_JAL, OPC_JALR: begin
                dec.d0 = inPc;
                dec.d1 = 32'd4;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec.op = ALU_ADD;
            dec.d0 = '0;
            dec.d1 = '0;
            dec.br = 1'b0;
            wr     = 1'b0;
        end
        dec.ill = !legal;
        dec.wrd = wr && (rd != 5'd0);
    end

    entry_t     mem [DEPTH];
    entry_t     head;
    logic [1:0] count;
    logic       wptr;
    logic       rptr;
    logic       push;
    logic       pop;

    assign inReady  = (count != 2'(DEPTH));
    assign outValid = (count != 2'd0);
    assign push     = inValid & inReady;
    assign pop      = outValid & outReady;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            count <= '0;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            count <= '0;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
        end else begin
            if (push) begin
                mem[wptr] <= dec;
                wptr      <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Outputs are a pure mux of stored entries, never of inputs.
    assign head      = mem[rptr];
    assign dataIn0   = head.d0;
    assign dataIn1   = head.d1;
    assign operation = head.op;
    assign rdIndex   = head.rd;
    assign writesRd  = head.wrd;
    assign isBranch  = head.br;
    assign illegal   = head.ill;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed plan steps, then random traffic
// checked against a queue-based reference of the issue buffer.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        flush = 1'b0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [31:0] inInstr = '0;
    logic [31:0] inPc = '0;
    logic [31:0] inRs1Val = '0;
    logic [31:0] inRs2Val = '0;
    logic        outValid;
    logic        outReady = 1'b0;
    logic [31:0] dataIn0;
    logic [31:0] dataIn1;
    logic [3:0]  operation;
    logic [4:0]  rdIndex;
    logic        writesRd;
    logic        isBranch;
    logic        illegal;

    always #5 clk = ~clk;

    alu_issue #(.DEPTH(2)) dut (
        .clk(clk), .rstN(rstN), .flush(flush),
        .inValid(inValid), .inReady(inReady),
        .inInstr(inInstr), .inPc(inPc),
        .inRs1Val(inRs1Val), .inRs2Val(inRs2Val),
        .outValid(outValid), .outReady(outReady),
        .dataIn0(dataIn0), .dataIn1(dataIn1),
        .operation(operation), .rdIndex(rdIndex),
        .writesRd(writesRd), .isBranch(isBranch),
        .illegal(illegal)
    );

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        int          op;
        logic [4:0]  rd;
        bit          wrd;
        bit          br;
        bit          ill;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // R/I-type arithmetic: returns ALU code, or -1 if the funct is illegal.
    function automatic int arith(input int f3, input logic [6:0] f7,
                                 input bit imm);
        if (f3 == 0) begin
            if (imm || f7 == 7'h00) return 6;
            return (f7 == 7'h20) ? 10 : -1;
        end
        if (f3 == 1) return (f7 == 7'h00) ? 11 : -1;
        if (f3 == 5) begin
            if (f7 == 7'h00) return 12;
            return (f7 == 7'h20) ? 13 : -1;
        end
        if (!imm && f7 != 7'h00) return -1;
        case (f3)
            2: return 2;
            3: return 4;
            4: return 7;
            6: return 8;
            default: return 9;
        endcase
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] i,
                                        input logic [31:0] pc,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
        exp_t e;
        int f3;
        int code;
        bit wr;
        logic [31:0] imm_i;
        logic [31:0] imm_s;
        logic [31:0] imm_u;
        f3 = int'(i[14:12]);
        imm_i = 32'($signed(i) >>> 20);
        imm_s = (32'($signed(i) >>> 25) << 5) | {27'b0, i[11:7]};
        imm_u = i & 32'hFFFF_F000;
        e.rd = i[11:7];
        e.br = 0;
        e.d0 = 0;
        e.d1 = 0;
        wr = 1;
        code = 6;
        case (i[6:0])
            7'h33: begin code = arith(f3, i[31:25], 0); e.d0 = a; e.d1 = b; end
            7'h13: begin code = arith(f3, i[31:25], 1); e.d0 = a; e.d1 = imm_i; end
            7'h63: begin
                code = (f3 == 2 || f3 == 3) ? -1 : (f3 < 2 ? f3 : f3 - 2);
                e.d0 = a; e.d1 = b; e.br = 1; wr = 0;
            end
            7'h03: begin e.d0 = a; e.d1 = imm_i; end
            7'h23: begin e.d0 = a; e.d1 = imm_s; wr = 0; end
            7'h37: e.d1 = imm_u;
            7'h17: begin e.d0 = pc; e.d1 = imm_u; end
            7'h6F, 7'h67: begin e.d0 = pc; e.d1 = 4; end
            default: code = -1;
        endcase
        e.ill = (code < 0);
        if (e.ill) begin
            code = 6; e.d0 = 0; e.d1 = 0; e.br = 0; wr = 0;
        end
        e.op = code;
        e.wrd = wr && (e.rd != 0);
        return e;
    endfunction

    task automatic compare_all();
        chk("inReady", inReady, q.size() < 2);
        chk("outValid", outValid, q.size() > 0);
        if (q.size() > 0) begin
            chk("dataIn0", dataIn0, q[0].d0);
            chk("dataIn1", dataIn1, q[0].d1);
            chk("operation", operation, q[0].op);
            chk("rdIndex", rdIndex, q[0].rd);
            chk("writesRd", writesRd, q[0].wrd);
            chk("isBranch", isBranch, q[0].br);
            chk("illegal", illegal, q[0].ill);
        end
    endtask

    task automatic cycle(input bit v, input logic [31:0] ins,
                         input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] b, input bit ordy,
                         input bit fl = 0, input bit rst = 1);
        bit acc;
        bit pp;
        exp_t e;
        inValid = v; inInstr = ins; inPc = pc;
        inRs1Val = a; inRs2Val = b;
        outReady = ordy; flush = fl; rstN = rst;
        acc = v && q.size() < 2;
        pp = ordy && q.size() > 0;
        e = ref_decode(ins, pc, a, b);
        @(posedge clk);
        #1;
        if (!rst || fl) begin
            q.delete();
        end else begin
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        compare_all();
    endtask

    task automatic idle(input bit ordy);
        cycle(0, 0, 0, 0, 0, ordy);
    endtask

    function automatic logic [31:0] addi(input logic [4:0] rd,
                                         input logic [11:0] imm);
        return {imm, 5'd1, 3'b000, rd, 7'h13};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] i;
        i = $urandom;
        case ($urandom_range(0, 9))
            0: i[6:0] = 7'h33;
            1: i[6:0] = 7'h13;
            2: i[6:0] = 7'h63;
            3: i[6:0] = 7'h03;
            4: i[6:0] = 7'h23;
            5: i[6:0] = 7'h37;
            6: i[6:0] = 7'h17;
            7: i[6:0] = 7'h6F;
            8: i[6:0] = 7'h67;
            default: ;
        endcase
        case ($urandom_range(0, 3))
            0, 1: i[31:25] = 7'h00;
            2: i[31:25] = 7'h20;
            default: ;
        endcase
        return i;
    endfunction

    initial begin
        // reset then idle
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_outValid", outValid, 0);
        chk("rst_inReady", inReady, 1);
        chk("rst_dataIn0", dataIn0, 0);
        chk("rst_dataIn1", dataIn1, 0);
        chk("rst_operation", operation, 0);
        chk("rst_rdIndex", rdIndex, 0);
        chk("rst_flags", {writesRd, isBranch, illegal}, 0);
        idle(0);

        // SUB x3,x1,x2
        cycle(1, 32'h402081B3, 32'h40, 10, 3, 1);
        chk("sub_op", operation, 10);
        chk("sub_d0", dataIn0, 10);
        chk("sub_d1", dataIn1, 3);
        chk("sub_rd", rdIndex, 3);
        chk("sub_wrd", writesRd, 1);
        idle(1);

        // BLTU x1,x2
        cycle(1, 32'h0020E063, 32'h44, 32'hFFFF_FFFF, 1, 1);
        chk("bltu_op", operation, 4);
        chk("bltu_br", isBranch, 1);
        chk("bltu_wrd", writesRd, 0);
        idle(1);

        // AUIPC x5,0x12345
        cycle(1, 32'h12345297, 32'h100, 7, 9, 1);
        chk("auipc_op", operation, 6);
        chk("auipc_d0", dataIn0, 32'h100);
        chk("auipc_d1", dataIn1, 32'h1234_5000);
        idle(1);

        // backpressure: three pushes, third held
        cycle(1, addi(5'd1, 12'h011), 0, 100, 0, 0);
        cycle(1, addi(5'd2, 12'h022), 0, 200, 0, 0);
        chk("bp_full", inReady, 0);
        cycle(1, addi(5'd3, 12'h033), 0, 300, 0, 0);
        chk("bp_head", rdIndex, 1);
        chk("bp_head_d1", dataIn1, 32'h11);
        idle(1);
        chk("bp_second", rdIndex, 2);
        chk("bp_second_d0", dataIn0, 200);
        idle(1);
        chk("bp_drained", outValid, 0);

        // push + pop at count 1
        cycle(1, addi(5'd4, 12'h044), 0, 1, 0, 0);
        cycle(1, addi(5'd5, 12'h055), 0, 2, 0, 1);
        chk("pp_valid", outValid, 1);
        chk("pp_ready", inReady, 1);
        chk("pp_head", rdIndex, 5);
        idle(1);
        chk("pp_empty", outValid, 0);

        // illegal opcode
        cycle(1, 32'h0000_007F, 32'h200, 32'h55, 32'h66, 0);
        chk("ill_flag", illegal, 1);
        chk("ill_op", operation, 6);
        chk("ill_d", dataIn0 | dataIn1, 0);
        idle(1);

        // flush with two entries plus a push
        cycle(1, addi(5'd6, 12'h001), 0, 1, 0, 0);
        cycle(1, addi(5'd7, 12'h002), 0, 1, 0, 0);
        cycle(1, addi(5'd8, 12'h003), 0, 1, 0, 1, 1);
        chk("fl_valid", outValid, 0);
        chk("fl_ready", inReady, 1);
        cycle(1, addi(5'd9, 12'h004), 0, 1, 0, 0);
        cycle(1, addi(5'd10, 12'h005), 0, 1, 0, 0, 1);
        chk("fl1_valid", outValid, 0);
        idle(1);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            bit rst;
            rst = ($urandom_range(0, 199) != 0);
            cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom,
                  $urandom, $urandom, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 39) == 0, rst);
            if (!rst) chk("rnd_rst_d0", dataIn0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
